// File: rtl/alu_wb_queue.sv
// alu_wb_queue: consumer end of the Gumnut ALU result interface.
// Captures each ALU result, maintains the Z/C condition flags and queues
// register-file writes in a small FIFO drained under a valid/ready handshake.
// Optional macro ALUWB_BYPASS_EN: when the queue is empty and the register
// file is ready, a write goes straight through in the same cycle.
module alu_wb_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [7:0]    res_i,
  input  logic          cout_i,
  input  logic [AW-1:0] rd_i,
  input  logic          wr_en_i,
  input  logic          flag_en_i,
  output logic          rf_we_o,
  output logic [AW-1:0] rf_waddr_o,
  output logic [7:0]    rf_wdata_o,
  input  logic          rf_ready_i,
  output logic          z_o,
  output logic          c_o,
  output logic          busy_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Queue storage: destination address and data per entry.
  logic [AW-1:0] addr_mem [DEPTH];
  logic [7:0]    data_mem [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic          z_reg, z_next;
  logic          c_reg, c_next;

  logic acc;
  logic wr_req;
  logic enq;
  logic deq;
  logic not_empty;
  logic bypass;

  // ready depends only on occupancy, never on the register file side.
  assign ready_o   = (count_reg != CW'(DEPTH));
  assign not_empty = (count_reg != '0);
  assign acc       = valid_i & ready_o;
  // Writes to r0 are discarded; r0 always reads as zero.
  assign wr_req    = acc & wr_en_i & (rd_i != '0);

`ifdef ALUWB_BYPASS_EN
  // An empty queue with a ready register file lets the result skip the FIFO.
  assign bypass     = wr_req & ~not_empty & rf_ready_i;
  assign enq        = wr_req & ~bypass;
  assign rf_we_o    = not_empty | bypass;
  assign rf_waddr_o = bypass ? rd_i  : addr_mem[head_reg];
  assign rf_wdata_o = bypass ? res_i : data_mem[head_reg];
  assign deq        = not_empty & rf_ready_i;
`else
  // All register-file outputs come straight from the queue head.
  assign bypass     = 1'b0;
  assign enq        = wr_req;
  assign rf_we_o    = not_empty;
  assign rf_waddr_o = addr_mem[head_reg];
  assign rf_wdata_o = data_mem[head_reg];
  assign deq        = rf_we_o & rf_ready_i;
`endif

  assign busy_o = not_empty;
  assign z_o    = z_reg;
  assign c_o    = c_reg;

  // Next-state for pointers, occupancy and flags.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    z_next     = z_reg;
    c_next     = c_reg;
    if (acc && flag_en_i) begin
      z_next = (res_i == 8'h00);
      c_next = cout_i;
    end
    if (enq) begin
      tail_next = PW'(tail_reg + 1'b1);
    end
    if (deq) begin
      head_next = PW'(head_reg + 1'b1);
    end
    case ({enq, deq})
      2'b10:   count_next = CW'(count_reg + 1'b1);
      2'b01:   count_next = CW'(count_reg - 1'b1);
      default: count_next = count_reg;
    endcase
  end

  // State register; reset drops any queued writes without issuing them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      z_reg     <= z_next;
      c_reg     <= c_next;
    end
  end

  // Entry storage is written at the tail; contents need no reset because
  // the occupancy count gates every use of them.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_mem[tail_reg] <= rd_i;
      data_mem[tail_reg] <= res_i;
    end
  end

  // bypass is only consumed when the optional path is compiled in.
  logic unused_bypass;
  assign unused_bypass = bypass;

endmodule

// File: tb/tb_alu_wb_queue.sv
// Self-checking bench for alu_wb_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_alu_wb_queue;

  localparam int DEPTH = 2;
  localparam int AW    = 3;

  logic          clk_i;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic [7:0]    res_i;
  logic          cout_i;
  logic [AW-1:0] rd_i;
  logic          wr_en_i;
  logic          flag_en_i;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [7:0]    rf_wdata_o;
  logic          rf_ready_i;
  logic          z_o;
  logic          c_o;
  logic          busy_o;

  alu_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .res_i      (res_i),
    .cout_i     (cout_i),
    .rd_i       (rd_i),
    .wr_en_i    (wr_en_i),
    .flag_en_i  (flag_en_i),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .rf_ready_i (rf_ready_i),
    .z_o        (z_o),
    .c_o        (c_o),
    .busy_o     (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ent_t;

  ent_t q[$];
  logic mz;
  logic mc;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then
  // advance the model by the rules for that edge.
  task automatic step(input logic v, input logic [7:0] res, input logic co,
                      input logic [AW-1:0] rd, input logic we, input logic fe,
                      input logic rfr, input logic rst);
    logic full;
    logic acc;
    logic wreq;
    logic byp;
    logic exp_we;
    ent_t e;
    @(negedge clk_i);
    valid_i    = v;
    res_i      = res;
    cout_i     = co;
    rd_i       = rd;
    wr_en_i    = we;
    flag_en_i  = fe;
    rf_ready_i = rfr;
    rst_ni     = ~rst;
    #1;
    full   = (q.size() == DEPTH);
    acc    = v && !full;
    wreq   = acc && we && (rd != '0);
    byp    = 1'b0;
`ifdef ALUWB_BYPASS_EN
    byp    = wreq && (q.size() == 0) && rfr;
`endif
    exp_we = (q.size() != 0) || byp;
    check("ready", ready_o, !full);
    check("rf_we", rf_we_o, exp_we);
    check("busy", busy_o, q.size() != 0);
    check("z", z_o, mz);
    check("c", c_o, mc);
    if (exp_we) begin
      if (byp) begin
        check("bypass_addr", rf_waddr_o, rd);
        check("bypass_data", rf_wdata_o, res);
      end else begin
        check("rf_waddr", rf_waddr_o, q[0].a);
        check("rf_wdata", rf_wdata_o, q[0].d);
      end
      if (rfr && !rst)
        $display("write r%0d = %02h%s", rf_waddr_o, rf_wdata_o, byp ? " (bypass)" : "");
    end
    @(posedge clk_i);
    if (rst) begin
      q.delete();
      mz = 1'b0;
      mc = 1'b0;
    end else begin
      if (acc && fe) begin
        mz = (res == 8'h00);
        mc = co;
      end
      if ((q.size() != 0) && rfr) e = q.pop_front();
      if (wreq && !byp) begin
        e.a = rd;
        e.d = res;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rfr);
    step(1'b0, 8'h00, 1'b0, '0, 1'b0, 1'b0, rfr, 1'b0);
  endtask

  initial begin
    valid_i = 0; res_i = 0; cout_i = 0; rd_i = 0;
    wr_en_i = 0; flag_en_i = 0; rf_ready_i = 0; rst_ni = 0;
    repeat (2) @(posedge clk_i);
    mz = 1'b0;
    mc = 1'b0;

    // Basic write with Z and C set.
    step(1, 8'h00, 1, 3'd3, 1, 1, 1, 0);
    idle(1);
    idle(1);

    // Fill while the register file stalls; third result must be refused.
    step(1, 8'h11, 0, 3'd1, 1, 0, 0, 0);
    step(1, 8'h22, 0, 3'd2, 1, 0, 0, 0);
    step(1, 8'h33, 0, 3'd5, 1, 0, 0, 0);
    idle(0);
    idle(1);
    idle(1);
    idle(1);

    // r0 destination: dropped, flags still update.
    step(1, 8'h05, 0, 3'd0, 1, 1, 1, 0);
    idle(1);

    // flag_en low: Z holds, write still queued.
    step(1, 8'h00, 1, 3'd6, 1, 0, 1, 0);
    idle(1);
    idle(1);

    // Reset with a full queue discards everything.
    step(1, 8'hAA, 1, 3'd1, 1, 1, 0, 0);
    step(1, 8'hBB, 0, 3'd2, 1, 0, 0, 0);
    step(0, 8'h00, 0, 3'd0, 0, 0, 1, 1);
    idle(1);
    idle(1);

`ifdef ALUWB_BYPASS_EN
    // Empty queue and ready register file: same-cycle write.
    step(1, 8'hA5, 0, 3'd4, 1, 0, 1, 0);
    idle(1);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), r, 1'($urandom),
           AW'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom),
           1'($urandom_range(0, 2) != 0), $urandom_range(0, 59) == 0);
    end
    repeat (4) idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
